// File: rtl/alu_pkg.sv
// Shared definitions for the byte-serial ALU issue path: op encodings, ALU width,
// and the sequencer state type.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam int         ALU_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/alu_byte_sequencer.sv
// Issues one wide command to an 8-bit combinational ALU one byte per clock (LSB first),
// chaining carry where the op calls for it, and returns the assembled wide result.
module alu_byte_sequencer
  import alu_pkg::*;
#(
  parameter int          NBYTES     = 2,
  parameter logic [15:0] CHAIN_MASK = 16'h0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [3:0]            cmd_oper,
  input  logic [8*NBYTES-1:0]   cmd_a,
  input  logic [8*NBYTES-1:0]   cmd_b,
  input  logic                  cmd_cin,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic [3:0]            alu_oper,
  output logic                  alu_cin,
  input  logic [7:0]            alu_sum,
  input  logic                  alu_cout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [8*NBYTES-1:0]   res_data,
  output logic                  res_cout
);

  localparam int W     = 8 * NBYTES;
  localparam int CNT_W = $clog2(NBYTES) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  seq_state_t       r_state;
  logic [W-1:0]     r_a_sh;
  logic [W-1:0]     r_b_sh;
  logic [W-1:0]     r_res_sh;
  logic [W-1:0]     r_res_data;
  logic [3:0]       r_oper;
  logic             r_cin;
  logic             r_carry;
  logic             r_chain;
  logic [CNT_W-1:0] r_cnt;
  logic             r_res_cout;
  logic             r_cmd_ready;
  logic             r_res_valid;
  logic [W-1:0]     w_res_next;

  // New byte enters at the top; shift form keeps NBYTES=1 legal (no empty slice).
  assign w_res_next = (r_res_sh >> ALU_W) | (W'(alu_sum) << (W - ALU_W));

  assign alu_a     = r_a_sh[ALU_W-1:0];
  assign alu_b     = r_b_sh[ALU_W-1:0];
  assign alu_oper  = r_oper;
  assign alu_cin   = r_carry;
  assign cmd_ready = r_cmd_ready;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_cout  = r_res_cout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_res_sh    <= '0;
      r_res_data  <= '0;
      r_oper      <= '0;
      r_cin       <= 1'b0;
      r_carry     <= 1'b0;
      r_chain     <= 1'b0;
      r_cnt       <= '0;
      r_res_cout  <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_a_sh      <= cmd_a;
            r_b_sh      <= cmd_b;
            r_oper      <= cmd_oper;
            r_cin       <= cmd_cin;
            r_carry     <= cmd_cin;
            r_chain     <= CHAIN_MASK[cmd_oper];
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_state     <= RUN;
          end
        end
        RUN: begin
          r_res_sh <= w_res_next;
          r_a_sh   <= r_a_sh >> ALU_W;
          r_b_sh   <= r_b_sh >> ALU_W;
          r_carry  <= r_chain ? alu_cout : r_cin;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            r_res_data  <= w_res_next;
            r_res_cout  <= alu_cout;
            r_res_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE costs a cycle, so a handshake here never overlaps an accept.
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Directed bench for alu_byte_sequencer driving a small behavioural 8-bit ALU beside it;
// expected results go into a scoreboard queue at issue and are checked at the handshake.
module tb_alu_byte_sequencer;
  import alu_pkg::*;

  localparam int NB = 2;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_oper;
  logic [15:0]   cmd_a;
  logic [15:0]   cmd_b;
  logic          cmd_cin;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [3:0]    alu_oper;
  logic          alu_cin;
  logic [7:0]    alu_sum;
  logic          alu_cout;
  logic          res_valid;
  logic          res_ready;
  logic [15:0]   res_data;
  logic          res_cout;

  typedef struct {
    logic [15:0] d;
    logic        c;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail    = 0;

  alu_byte_sequencer #(.NBYTES(NB), .CHAIN_MASK(16'h0001)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_oper  (cmd_oper),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_cin   (cmd_cin),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_oper  (alu_oper),
    .alu_cin   (alu_cin),
    .alu_sum   (alu_sum),
    .alu_cout  (alu_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_cout  (res_cout)
  );

  // Behavioural ALU: 0 add, 1 subtract (carry = not-borrow), 2 and, others xor.
  logic [7:0] nb;
  logic [8:0] alu_wide;
  always_comb begin
    nb       = ~alu_b;
    alu_wide = '0;
    case (alu_oper)
      4'd0:    alu_wide = 9'(alu_a) + 9'(alu_b) + 9'(alu_cin);
      4'd1:    alu_wide = 9'(alu_a) + 9'(nb) + 9'(alu_cin);
      4'd2:    alu_wide = {1'b0, alu_a & alu_b};
      default: alu_wide = {1'b0, alu_a ^ alu_b};
    endcase
  end
  assign alu_sum  = alu_wide[7:0];
  assign alu_cout = alu_wide[8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                      input logic cin, input logic [15:0] exp_d, input logic exp_c);
    exp_t e;
    @(negedge clk);
    cmd_oper  = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_cin   = cin;
    cmd_valid = 1'b1;
    check("cmd_ready_at_issue", 32'(cmd_ready), 32'd1);
    e.d = exp_d;
    e.c = exp_c;
    sb.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Called just after the accepting edge; records alu_cin per byte and edges until res_valid.
  task automatic run_bytes(output logic [NB-1:0] cins, output int lat);
    lat  = 0;
    cins = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (res_valid) break;
      if (k < NB) cins[k] = alu_cin;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic take_result(input string tag);
    exp_t e;
    check({tag, "_res_valid"}, 32'(res_valid), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_res_data"}, 32'(res_data), 32'(e.d));
      check({tag, "_res_cout"}, 32'(res_cout), 32'(e.c));
    end else begin
      check({tag, "_scoreboard_nonempty"}, 32'd0, 32'd1);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check({tag, "_idle_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_idle_cmd_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  logic [NB-1:0] cins;
  int            lat;

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_oper  = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_cin   = 1'b0;
    res_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
    check("rst_res_cout",  32'(res_cout),  32'd0);
    check("rst_alu_a",     32'(alu_a),     32'd0);
    check("rst_alu_b",     32'(alu_b),     32'd0);
    check("rst_alu_oper",  32'(alu_oper),  32'd0);
    check("rst_alu_cin",   32'(alu_cin),   32'd0);

    // Carry ripples from byte 0 into byte 1
    send(OP_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    run_bytes(cins, lat);
    check("add1_latency", 32'(lat), 32'd2);
    check("add1_cins", 32'(cins), 32'b10);
    take_result("add1");

    // Carry out of the top byte
    send(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_bytes(cins, lat);
    check("add2_latency", 32'(lat), 32'd2);
    check("add2_cins", 32'(cins), 32'b10);
    take_result("add2");

    // Unchained op: every byte sees cmd_cin
    send(4'd1, 16'h12FF, 16'h3401, 1'b1, 16'hDEFE, 1'b0);
    run_bytes(cins, lat);
    check("sub_latency", 32'(lat), 32'd2);
    check("sub_cins", 32'(cins), 32'b11);
    take_result("sub");

    // Chained add with carry-in
    send(OP_ADD, 16'h7F80, 16'h0080, 1'b1, 16'h8001, 1'b0);
    run_bytes(cins, lat);
    check("addc_cins", 32'(cins), 32'b11);
    take_result("addc");

    // Unchained logic op with cin=0
    send(4'd2, 16'hA5F0, 16'h0FFF, 1'b0, 16'h05F0, 1'b0);
    run_bytes(cins, lat);
    check("and_cins", 32'(cins), 32'b00);
    take_result("and");

    // Stall in DONE with a competing command present
    send(OP_ADD, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    run_bytes(cins, lat);
    check("stall_latency", 32'(lat), 32'd2);
    cmd_valid = 1'b1;
    cmd_oper  = OP_ADD;
    cmd_a     = 16'hAAAA;
    cmd_b     = 16'h5555;
    cmd_cin   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_res_valid", 32'(res_valid), 32'd1);
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      check("stall_res_data",  32'(res_data),  32'h5555);
      check("stall_res_cout",  32'(res_cout),  32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    take_result("stall");
    @(posedge clk);
    @(negedge clk);
    check("stall_not_consumed_ready", 32'(cmd_ready), 32'd1);
    check("stall_not_consumed_valid", 32'(res_valid), 32'd0);

    // Reset mid-command aborts it
    send(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    sb.delete(sb.size() - 1);
    @(negedge clk);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_res_valid", 32'(res_valid), 32'd0);
    check("abort_res_data",  32'(res_data),  32'd0);
    check("abort_alu_cin",   32'(alu_cin),   32'd0);
    send(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_bytes(cins, lat);
    check("post_abort_latency", 32'(lat), 32'd2);
    take_result("post_abort");

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
